// File: rtl/ov7670_pkg.sv
// -----------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the OV7670 framebuffer reader:
//   - fb_state_t     : reader FSM state encoding
//   - CNT_W          : width of the x/y position counters
//   - RGB565_HI_FIRST: byte order of a pixel in the framebuffer (1 = the first
//                      byte read is the high byte of the RGB565 word)
//   - pack_rgb565()  : joins the two fetched bytes into one RGB565 word
// -----------------------------------------------------------------------------
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    LATCH_LO = 3'd3,
    PRESENT  = 3'd4,
    DONE     = 3'd5
  } fb_state_t;

  localparam int unsigned CNT_W = 16;

  localparam logic RGB565_HI_FIRST = 1'b1;

  function automatic logic [15:0] pack_rgb565(input logic [7:0] first_byte,
                                              input logic [7:0] second_byte);
    return RGB565_HI_FIRST ? {first_byte, second_byte} : {second_byte, first_byte};
  endfunction

endpackage

// File: rtl/ov7670_pixel_counter.sv
// -----------------------------------------------------------------------------
// ov7670_pixel_counter
// Tracks the (x, y) position of the pixel currently being streamed.
// Ports:
//   pclk_24  in  : clock, rising edge
//   reset_n  in  : asynchronous active-low reset
//   clear    in  : return to (0,0) at the start of a frame
//   advance  in  : step to the next pixel (x wraps to 0 with y+1 at line end)
//   x, y     out : current position
//   sol      out : x == 0
//   eol      out : x == H_PIXELS-1
//   eof      out : last pixel of the frame
// -----------------------------------------------------------------------------
module ov7670_pixel_counter
  import ov7670_pkg::*;
#(
  parameter int unsigned H_PIXELS = 160,
  parameter int unsigned V_LINES  = 120
) (
  input  logic             pclk_24,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             sol,
  output logic             eol,
  output logic             eof
);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             w_eol;

  assign w_eol = (r_x == CNT_W'(H_PIXELS - 1));

  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign x   = r_x;
  assign y   = r_y;
  assign sol = (r_x == '0);
  assign eol = w_eol;
  assign eof = w_eol && (r_y == CNT_W'(V_LINES - 1));

endmodule

// File: rtl/ov7670_fb_reader.sv
// -----------------------------------------------------------------------------
// ov7670_fb_reader
// Streams one frame of RGB565 pixels out of a byte-wide framebuffer with a
// one-cycle read latency, two bytes per pixel, onto a valid/ready stream.
// Ports:
//   pclk_24     in  : clock, all logic on rising edge
//   reset_n     in  : asynchronous active-low reset
//   start       in  : stream one frame (sampled in IDLE only)
//   busy        out : high whenever the reader is not IDLE
//   fb_addr     out : framebuffer byte address
//   fb_rd_en    out : framebuffer read strobe
//   fb_din      in  : read data, valid one cycle after fb_rd_en
//   m_valid     out : pixel valid
//   m_ready     in  : downstream accepts pixel
//   m_data      out : RGB565 pixel
//   m_sol/eol/eof out : first-of-line / last-of-line / last-of-frame flags
//   frame_done  out : one-cycle pulse after the last pixel is accepted
// -----------------------------------------------------------------------------
module ov7670_fb_reader
  import ov7670_pkg::*;
#(
  parameter int unsigned H_PIXELS  = 160,
  parameter int unsigned V_LINES   = 120,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        pclk_24,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic [15:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [7:0]  fb_din,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_sol,
  output logic        m_eol,
  output logic        m_eof,
  output logic        frame_done
);

  fb_state_t        r_state;
  fb_state_t        w_next;
  logic [15:0]      r_ptr;
  logic [7:0]       r_hi;
  logic [15:0]      r_data;
  logic             r_sol;
  logic             r_eol;
  logic             r_eof;
  logic             w_clear;
  logic             w_advance;
  logic             w_ptr_inc;
  logic             w_rd_en;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             w_sol;
  logic             w_eol;
  logic             w_eof;
  logic             w_unused_pos;

  ov7670_pixel_counter #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES)
  ) u_pixel_counter (
    .pclk_24 (pclk_24),
    .reset_n (reset_n),
    .clear   (w_clear),
    .advance (w_advance),
    .x       (w_x),
    .y       (w_y),
    .sol     (w_sol),
    .eol     (w_eol),
    .eof     (w_eof)
  );

  // Raw x/y are only needed for the flags; they stay visible for debug.
  assign w_unused_pos = ^{w_x, w_y};

  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_advance = 1'b0;
    w_ptr_inc = 1'b0;
    w_rd_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = FETCH_HI;
        end
      end
      FETCH_HI: begin
        w_rd_en   = 1'b1;
        w_ptr_inc = 1'b1;
        w_next    = FETCH_LO;
      end
      FETCH_LO: begin
        w_rd_en   = 1'b1;
        w_ptr_inc = 1'b1;
        w_next    = LATCH_LO;
      end
      LATCH_LO: begin
        w_next = PRESENT;
      end
      PRESENT: begin
        if (m_ready) begin
          if (r_eof) begin
            w_next = DONE;
          end else begin
            w_advance = 1'b1;
            w_next    = FETCH_HI;
          end
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Byte pointer: loaded at frame start, bumped once per issued read.
  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_clear) begin
      r_ptr <= BASE_ADDR;
    end else if (w_ptr_inc) begin
      r_ptr <= r_ptr + 16'd1;
    end
  end

  // The read issued in FETCH_HI returns during FETCH_LO, the one from
  // FETCH_LO returns during LATCH_LO; the pixel word and its position flags
  // are captured together so they stay consistent while PRESENT stalls.
  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      r_hi   <= '0;
      r_data <= '0;
      r_sol  <= 1'b0;
      r_eol  <= 1'b0;
      r_eof  <= 1'b0;
    end else begin
      if (r_state == FETCH_LO) begin
        r_hi <= fb_din;
      end
      if (r_state == LATCH_LO) begin
        r_data <= pack_rgb565(r_hi, fb_din);
        r_sol  <= w_sol;
        r_eol  <= w_eol;
        r_eof  <= w_eof;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign fb_addr    = r_ptr;
  assign fb_rd_en   = w_rd_en;
  assign m_valid    = (r_state == PRESENT);
  assign m_data     = r_data;
  assign m_sol      = r_sol;
  assign m_eol      = r_eol;
  assign m_eof      = r_eof;
  assign frame_done = (r_state == DONE);

endmodule

// File: tb/tb_ov7670_fb_reader.sv
`timescale 1ns/1ps
module tb_ov7670_fb_reader;

  localparam int          H    = 4;
  localparam int          V    = 2;
  localparam int          NPIX = H * V;
  localparam logic [15:0] BASE = 16'h1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start_a, ready_a, start_c, ready_c;
  logic        busy_a, rd_a, valid_a, sol_a, eol_a, eof_a, done_a;
  logic [15:0] addr_a, data_a;
  logic [7:0]  din_a = 8'h00;
  logic        busy_c, rd_c, valid_c, sol_c, eol_c, eof_c, done_c;
  logic [15:0] addr_c, data_c;
  logic [7:0]  din_c = 8'h00;

  logic [7:0] mem [0:65535];

  ov7670_fb_reader #(.H_PIXELS(H), .V_LINES(V), .BASE_ADDR(BASE)) dut_a (
    .pclk_24(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a),
    .fb_addr(addr_a), .fb_rd_en(rd_a), .fb_din(din_a), .m_valid(valid_a),
    .m_ready(ready_a), .m_data(data_a), .m_sol(sol_a), .m_eol(eol_a),
    .m_eof(eof_a), .frame_done(done_a)
  );

  ov7670_fb_reader #(.H_PIXELS(1), .V_LINES(1), .BASE_ADDR(16'h0000)) dut_c (
    .pclk_24(clk), .reset_n(reset_n), .start(start_c), .busy(busy_c),
    .fb_addr(addr_c), .fb_rd_en(rd_c), .fb_din(din_c), .m_valid(valid_c),
    .m_ready(ready_c), .m_data(data_c), .m_sol(sol_c), .m_eol(eol_c),
    .m_eof(eof_c), .frame_done(done_c)
  );

  // Framebuffer RAM with one cycle of read latency.
  always @(posedge clk) if (rd_a) din_a <= mem[addr_a];
  always @(posedge clk) if (rd_c) din_c <= mem[addr_c];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model of the streamed frame -------------------
  // m_idle   : reader waiting for start
  // cnt      : cycles left before the current pixel is presented
  //            (3,2 = the two byte reads, 1 = capture, 0 = presenting)
  // k        : index of the pixel being produced; rd_k: reads issued so far
  bit          m_idle    = 1'b1;
  bit          done_pend = 1'b0;
  int          cnt       = 0;
  int          k         = 0;
  int          rd_k      = 0;
  int          done_cnt  = 0;
  bit          e_valid, e_rd;
  logic [15:0] data_q[$];
  logic        eol_q[$];
  logic [15:0] addr_q[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_busy",       busy_a,  1'b0);
      chk("rst_fb_rd_en",   rd_a,    1'b0);
      chk("rst_m_valid",    valid_a, 1'b0);
      chk("rst_flags",      {sol_a, eol_a, eof_a}, 3'b000);
      chk("rst_frame_done", done_a,  1'b0);
      chk("rst_fb_addr",    addr_a,  16'h0000);
      chk("rst_m_data",     data_a,  16'h0000);
      m_idle    = 1'b1;
      done_pend = 1'b0;
      cnt       = 0;
    end else begin
      e_valid = !m_idle && !done_pend && (cnt == 0);
      e_rd    = !m_idle && !done_pend && (cnt == 3 || cnt == 2);
      chk("busy",       busy_a,  !m_idle);
      chk("frame_done", done_a,  done_pend);
      chk("m_valid",    valid_a, e_valid);
      chk("fb_rd_en",   rd_a,    e_rd);
      if (rd_a) begin
        chk("fb_addr", addr_a, 16'(BASE + rd_k));
        addr_q.push_back(addr_a);
        rd_k++;
      end
      if (e_valid) begin
        chk("m_data", data_a, {mem[BASE + 2 * k], mem[BASE + 2 * k + 1]});
        chk("m_sol",  sol_a,  (k % H) == 0);
        chk("m_eol",  eol_a,  (k % H) == H - 1);
        chk("m_eof",  eof_a,  k == NPIX - 1);
      end
      if (done_a) done_cnt++;
      if (done_pend) begin
        done_pend = 1'b0;
        m_idle    = 1'b1;
      end else if (m_idle) begin
        if (start_a) begin
          m_idle = 1'b0;
          cnt    = 3;
          k      = 0;
          rd_k   = 0;
        end
      end else if (cnt != 0) begin
        cnt--;
      end else if (ready_a) begin
        data_q.push_back(data_a);
        eol_q.push_back(eol_a);
        if (k == NPIX - 1) begin
          done_pend = 1'b1;
        end else begin
          k++;
          cnt = 3;
        end
      end
    end
  end

  // mode 0: always ready; 1: stall 10 cycles on pixel 2;
  // 2: random ready + stray starts; 3: start pulse while pixel 3 is shown
  task automatic run_frame(input int mode, input string tag);
    int          t0 = done_cnt;
    int          stall = 10;
    int          guard = 0;
    logic [15:0] hold_addr = 16'h0;
    data_q.delete();
    eol_q.delete();
    addr_q.delete();
    start_a = 1'b1;
    ready_a = 1'b1;
    tick;
    start_a = 1'b0;
    while (done_cnt == t0 && guard < 400) begin
      case (mode)
        1: begin
          if (valid_a && data_q.size() == 2 && stall > 0) begin
            chk("stall_data", data_a, 16'h0405);
            if (stall == 10) hold_addr = addr_a;
            else begin
              chk("stall_addr",  addr_a, hold_addr);
              chk("stall_rd_en", rd_a,   1'b0);
            end
            ready_a = 1'b0;
            stall--;
          end else begin
            ready_a = 1'b1;
          end
        end
        2: begin
          ready_a = ($urandom_range(2) != 0);
          start_a = busy_a && ($urandom_range(3) == 0);
        end
        3: begin
          ready_a = 1'b1;
          start_a = valid_a && (data_q.size() == 3);
        end
        default: ready_a = 1'b1;
      endcase
      tick;
      guard++;
    end
    start_a = 1'b0;
    ready_a = 1'b0;
    repeat (4) tick;
    chk({tag, "_frame_done_count"}, done_cnt - t0, 1);
    chk({tag, "_pixel_count"}, data_q.size(), NPIX);
    chk({tag, "_idle_after"}, busy_a, 1'b0);
  endtask

  initial begin
    int lat;
    int d0;
    reset_n = 1'b0;
    start_a = 1'b0;
    ready_a = 1'b0;
    start_c = 1'b0;
    ready_c = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int n = 0; n < 2 * NPIX; n++) mem[BASE + n] = 8'(n);
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    repeat (3) tick;
    reset_n = 1'b1;
    tick;

    // Known ramp frame with a 10-cycle stall on pixel 2.
    run_frame(1, "ramp");
    chk("px0",   data_q[0], 16'h0001);
    chk("px1",   data_q[1], 16'h0203);
    chk("px2",   data_q[2], 16'h0405);
    chk("px7",   data_q[7], 16'h0E0F);
    chk("eol2",  eol_q[2],  1'b0);
    chk("eol3",  eol_q[3],  1'b1);
    chk("eol7",  eol_q[7],  1'b1);
    chk("addr_first",  addr_q[0],  16'h1000);
    chk("addr_second", addr_q[1],  16'h1001);
    chk("addr_last",   addr_q[15], 16'h100F);
    chk("addr_count",  addr_q.size(), 16);

    // Start during pixel 3 must not restart or extend the frame.
    run_frame(3, "start_mid");
    chk("start_mid_px7", data_q[7], 16'h0E0F);

    // 1x1 frame on the second instance.
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    lat = 1;
    while (!valid_c && lat < 20) begin
      tick;
      lat++;
    end
    chk("c_latency", lat, 4);
    chk("c_flags", {sol_c, eol_c, eof_c}, 3'b111);
    chk("c_data", data_c, 16'hA53C);
    ready_c = 1'b1;
    tick;
    ready_c = 1'b0;
    chk("c_frame_done", done_c, 1'b1);
    chk("c_busy_done", busy_c, 1'b1);
    tick;
    chk("c_frame_done_end", done_c, 1'b0);
    chk("c_busy_end", busy_c, 1'b0);

    // Random frames with random contents and backpressure.
    for (int f = 0; f < 8; f++) begin
      for (int n = 0; n < 2 * NPIX; n++) mem[BASE + n] = 8'($urandom);
      run_frame(2, "random");
    end

    // Reset dropped during FETCH_LO.
    for (int n = 0; n < 2 * NPIX; n++) mem[BASE + n] = 8'(n);
    d0 = done_cnt;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick;
    chk("pre_rst_rd_en", rd_a, 1'b1);
    chk("pre_rst_addr", addr_a, 16'h1001);
    reset_n = 1'b0;
    #1;
    chk("async_busy", busy_a, 1'b0);
    chk("async_rd_en", rd_a, 1'b0);
    chk("async_addr", addr_a, 16'h0000);
    chk("async_data", data_a, 16'h0000);
    chk("async_valid_flags", {valid_a, sol_a, eol_a, eof_a, done_a}, 5'b00000);
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    chk("no_done_after_abort", done_cnt - d0, 0);
    run_frame(0, "restart");
    chk("restart_addr", addr_q[0], 16'h1000);
    chk("restart_px0", data_q[0], 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d expected completion", vectors);
    $fatal(1);
  end

endmodule
